// File: rtl/wb_buffer.sv
// Write-back staging FIFO between the result-select mux and the
// register-file write port, with forwarding lookup and select screening.
module wb_buffer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [2:0]               in_sel,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [ADDR_W-1:0]        out_addr,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [WIDTH-1:0]         lookup_data,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic                     sel_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [2:0] BAD_SEL = 3'd7;

  logic [WIDTH-1:0]  mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              err;

  logic push_hs;
  logic store;
  logic pop;
  logic bad;

  logic [PW-1:0]     scan_idx;

  assign in_ready  = (cnt < FULL);
  assign out_valid = (cnt != '0);
  assign count     = cnt;
  assign sel_err   = err;

  // A flush swallows any handshake presented alongside it.
  assign bad     = (in_sel == BAD_SEL);
  assign push_hs = in_valid & in_ready & ~flush;
  assign store   = push_hs & ~bad;
  assign pop     = out_valid & out_ready & ~flush;

  // Head entry drives the write port; zero when nothing is queued.
  always_comb begin
    out_data = '0;
    out_addr = '0;
    if (out_valid) begin
      out_data = mem_data[rd_ptr];
      out_addr = mem_addr[rd_ptr];
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    scan_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PW'(i);
      if ((CW'(i) < cnt) &&
          (mem_addr[scan_idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_data[scan_idx];
      end
    end
  end

  // Entry storage; only screened words are written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
      end
    end else if (store) begin
      mem_data[wr_ptr] <= in_data;
      mem_addr[wr_ptr] <= in_addr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy tracks store/pop; simultaneous ones cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({store, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky select error; a new bad select beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (push_hs && bad) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_buffer.sv
// Directed and randomized checks of wb_buffer against
// a queue-based reference model.
module tb_wb_buffer;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [2:0]        in_sel;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [WIDTH-1:0]  lookup_data;
  logic              flush;
  logic              clr_err;
  logic              sel_err;
  logic [CW-1:0]     count;

  typedef struct packed {
    logic [WIDTH-1:0]  d;
    logic [ADDR_W-1:0] a;
  } ent_t;

  ent_t q[$];
  bit   m_err;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  wb_buffer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data),
    .flush(flush), .clr_err(clr_err), .sel_err(sel_err),
    .count(count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic check_outs();
    logic [WIDTH-1:0]  ed;
    logic [ADDR_W-1:0] ea;
    logic              eh;
    logic [WIDTH-1:0]  ld;
    ed = '0;
    ea = '0;
    eh = 1'b0;
    ld = '0;
    if (q.size() > 0) begin
      ed = q[0].d;
      ea = q[0].a;
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!eh && q[i].a == lookup_addr) begin
        eh = 1'b1;
        ld = q[i].d;
      end
    end
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_data", 32'(out_data), 32'(ed));
    chk("out_addr", 32'(out_addr), 32'(ea));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    chk("lookup_hit", 32'(lookup_hit), 32'(eh));
    chk("lookup_data", 32'(lookup_data), 32'(ld));
  endtask

  // Behaviour of one rising edge, from the rules rather than the RTL.
  task automatic model_edge();
    bit rdy;
    bit do_pop;
    bit do_push;
    rdy = (q.size() < DEPTH);
    if (flush) begin
      q.delete();
      if (clr_err) m_err = 1'b0;
    end else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && rdy;
      if (do_push && in_sel == 3'd7) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
      if (do_pop) void'(q.pop_front());
      if (do_push && in_sel != 3'd7)
        q.push_back('{d: in_data, a: in_addr});
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic push(input logic [15:0] d,
                      input logic [3:0] a,
                      input logic [2:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_addr  = a;
    in_sel   = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_data     = '0;
    in_sel      = '0;
    in_addr     = '0;
    out_ready   = 1'b0;
    lookup_addr = '0;
    flush       = 1'b0;
    clr_err     = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"}, 32'(out_data), 32'd0);
    chk({tag, ".out_addr"}, 32'(out_addr), 32'd0);
    chk({tag, ".hit"}, 32'(lookup_hit), 32'd0);
    chk({tag, ".ldata"}, 32'(lookup_data), 32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".sel_err"}, 32'(sel_err), 32'd0);
  endtask

  initial begin
    idle_inputs();
    m_err = 1'b0;
    rst_n = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t0.in_ready", 32'(in_ready), 32'd1);

    push(16'h1234, 4'd3, 3'd2);
    chk("t1.out_valid", 32'(out_valid), 32'd1);
    chk("t1.out_data", 32'(out_data), 32'h1234);
    chk("t1.out_addr", 32'(out_addr), 32'd3);
    chk("t1.count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    push(16'h00a1, 4'd1, 3'd0);
    push(16'h00b2, 4'd2, 3'd6);
    chk("t2.count", 32'(count), 32'd2);
    chk("t2.in_ready", 32'(in_ready), 32'd0);
    push(16'h00c3, 4'd7, 3'd1);
    chk("t2.held", 32'(count), 32'd2);
    chk("t2.head", 32'(out_data), 32'h00a1);
    out_ready = 1'b1;
    step();
    chk("t2.second", 32'(out_data), 32'h00b2);
    step();
    chk("t2.empty", 32'(count), 32'd0);
    out_ready = 1'b0;

    push(16'h3000, 4'd8, 3'd3);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h3000 + 16'(i);
      in_addr  = 4'(i);
      in_sel   = 3'(i % 7);
      step();
      chk("t3.count", 32'(count), 32'd1);
      chk("t3.order", 32'(out_data), 32'(16'h3000 + 16'(i)));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;

    push(16'haaaa, 4'd5, 3'd4);
    push(16'hbbbb, 4'd5, 3'd5);
    lookup_addr = 4'd5;
    #1;
    chk("t4.hit", 32'(lookup_hit), 32'd1);
    chk("t4.data", 32'(lookup_data), 32'hbbbb);
    lookup_addr = 4'd6;
    #1;
    chk("t4.miss", 32'(lookup_hit), 32'd0);
    chk("t4.mdata", 32'(lookup_data), 32'd0);
    lookup_addr = 4'd5;
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;

    push(16'hdead, 4'd9, 3'd7);
    chk("t5.count", 32'(count), 32'd0);
    chk("t5.err", 32'(sel_err), 32'd1);
    clr_err = 1'b1;
    push(16'hbeef, 4'd9, 3'd7);
    chk("t5.set_wins", 32'(sel_err), 32'd1);
    step();
    chk("t5.cleared", 32'(sel_err), 32'd0);
    clr_err = 1'b0;

    push(16'h0101, 4'd1, 3'd0);
    push(16'h0202, 4'd2, 3'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    push(16'h0303, 4'd3, 3'd7);
    flush = 1'b0;
    chk("t6.count", 32'(count), 32'd0);
    chk("t6.valid", 32'(out_valid), 32'd0);
    chk("t6.no_err", 32'(sel_err), 32'd0);
    out_ready = 1'b0;

    push(16'h0404, 4'd4, 3'd1);
    push(16'h0505, 4'd4, 3'd2);
    lookup_addr = 4'd4;
    out_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("t6.rst");
    q.delete();
    m_err = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int n = 0; n < 400; n++) begin
      in_valid    = 1'($urandom_range(0, 3) != 0);
      in_data     = 16'($urandom);
      in_addr     = 4'($urandom_range(0, 3));
      in_sel      = ($urandom_range(0, 9) == 0) ? 3'd7
                    : 3'($urandom_range(0, 6));
      out_ready   = 1'($urandom_range(0, 1));
      lookup_addr = 4'($urandom_range(0, 3));
      flush       = 1'($urandom_range(0, 24) == 0);
      clr_err     = 1'($urandom_range(0, 7) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
